seg7_scan: RTL and testbench

Four-digit multiplexed seven-segment driver for the Basys 3 display. It is the consumer of the 4-bit BCD digits produced by the calculator's per-digit counters and operand logic. It latches four digits once per frame, time-multiplexes them onto the shared active-low segment and anode pins, and applies an inter-digit blanking gap to suppress ghosting. Optional leading-zero suppression is provided.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_scan.sv | 92 +++++++++
 tb/tb_seg7_scan.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low digit patterns and frame payload.
package seg7_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0]   seg_t;

    // Patterns are {g,f,e,d,c,b,a}, active-low
    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

    typedef struct packed {
        bcd_t [NUM_DIGITS-1:0] digit;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
    } frame_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Digit source to display driver bundle: BCD digits in, multiplexed pins out.
interface seg7_scan_if;
    import seg7_pkg::*;

    bcd_t       digit0;
    bcd_t       digit1;
    bcd_t       digit2;
    bcd_t       digit3;
    logic [3:0] dp_in;
    logic [3:0] blank_in;
    logic [3:0] an;
    seg_t       seg;
    logic       dp_n;

    modport master (
        output digit0, digit1, digit2, digit3, dp_in, blank_in,
        input  an, seg, dp_n
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, dp_in, blank_in,
        output an, seg, dp_n
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; 10..15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame input latch,
// inter-digit blanking gap and optional leading-zero suppression.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_SUPPRESS  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    frame_t           shadow;

    logic [3:0]       an_q;
    seg_t             seg_q;
    logic             dp_n_q;

    logic             slot_end_c;
    logic             in_gap_c;
    logic [3:0]       lead_zero_c;
    logic             blank_c;
    seg_t             dec_seg_c;

    assign slot_end_c = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign in_gap_c   = (cnt < CNT_W'(BLANK_CYCLES));

    // Slot counter, scan index, and frame latch at the last cycle of slot 3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            if (slot_end_c) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shadow.digit <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
                    shadow.dp    <= bus.dp_in;
                    shadow.blank <= bus.blank_in;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // lead_zero_c[k]: digit k and every more significant digit are zero
    always_comb begin
        lead_zero_c    = '0;
        lead_zero_c[3] = (shadow.digit[3] == 4'd0);
        lead_zero_c[2] = lead_zero_c[3] && (shadow.digit[2] == 4'd0);
        lead_zero_c[1] = lead_zero_c[2] && (shadow.digit[1] == 4'd0);
        lead_zero_c[0] = 1'b0;
    end

    assign blank_c = shadow.blank[idx] | (LZ_SUPPRESS & lead_zero_c[idx]);

    seg7_decode u_decode (
        .bcd   (shadow.digit[idx]),
        .seg_c (dec_seg_c)
    );

    // Output registers; the gap at the start of every slot keeps anodes off across idx changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q   <= 4'hF;
            seg_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
        end else if (in_gap_c) begin
            an_q   <= 4'hF;
            seg_q  <= SEG_OFF;
            dp_n_q <= 1'b1;
        end else begin
            an_q   <= ~(4'b0001 << idx);
            seg_q  <= blank_c ? SEG_OFF : dec_seg_c;
            dp_n_q <= blank_c | ~shadow.dp[idx];
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp_n = dp_n_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: cycle-indexed display model compared every cycle,
// plus hand-computed slot expectations on a plain and a zero-suppressing instance.
module tb_seg7_scan;

    localparam int unsigned R     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = 4 * R;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_if b0 ();
    seg7_scan_if b1 ();

    seg7_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1'b0)) u_plain (
        .clk (clk), .rst (rst), .bus (b0)
    );
    seg7_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1'b1)) u_lz (
        .clk (clk), .rst (rst), .bus (b1)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] pat [16];

    // Model state: cycles since reset release and the digits the display is showing
    int         cyc;
    logic [3:0] sd [4];
    logic [3:0] sdp;
    logic [3:0] sbl;
    logic [3:0] exp_an  [2];
    logic [6:0] exp_seg [2];
    logic       exp_dp  [2];

    int         blank_run [2];
    logic [3:0] last_lit  [2];

    function automatic logic [11:0] model_out(int c, bit lz);
        int slot = c / R;
        int pos  = c % R;
        int k    = slot % 4;
        bit lead = 1'b1;
        logic [3:0] a = 4'hF;
        if (pos < B) return {4'hF, 7'h7F, 1'b1};
        a[k] = 1'b0;
        for (int j = k; j < 4; j++) if (sd[j] != 4'd0) lead = 1'b0;
        if (sbl[k] || (lz && k >= 1 && lead)) return {a, 7'h7F, 1'b1};
        return {a, pat[sd[k]], ~sdp[k]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int j = 0; j < 4; j++) sd[j] <= '0;
            sdp <= '0;
            sbl <= '0;
            for (int i = 0; i < 2; i++) begin
                exp_an[i]  <= 4'hF;
                exp_seg[i] <= 7'h7F;
                exp_dp[i]  <= 1'b1;
            end
        end else begin
            {exp_an[0], exp_seg[0], exp_dp[0]} <= model_out(cyc, 1'b0);
            {exp_an[1], exp_seg[1], exp_dp[1]} <= model_out(cyc, 1'b1);
            if (cyc % FRAME == FRAME - 1) begin
                sd[0] <= b0.digit0;
                sd[1] <= b0.digit1;
                sd[2] <= b0.digit2;
                sd[3] <= b0.digit3;
                sdp   <= b0.dp_in;
                sbl   <= b0.blank_in;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic compare_one(int i, logic [3:0] an, logic [6:0] sg, logic dp);
        checks++;
        if (an !== exp_an[i] || sg !== exp_seg[i] || dp !== exp_dp[i]) begin
            errors++;
            $display("FAIL model[%0d] c=%0d: got an=%b seg=%b dp_n=%b expected an=%b seg=%b dp_n=%b",
                     i, cyc - 1, an, sg, dp, exp_an[i], exp_seg[i], exp_dp[i]);
        end
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot[%0d]: got an=%b expected at most one low anode", i, an);
        end
        if (an == 4'hF) begin
            blank_run[i]++;
        end else begin
            if (last_lit[i] != 4'hF && an != last_lit[i]) begin
                checks++;
                if (blank_run[i] < 2) begin
                    errors++;
                    $display("FAIL gap[%0d]: got %0d blank cycles before an=%b expected >= 2",
                             i, blank_run[i], an);
                end
            end
            last_lit[i]  = an;
            blank_run[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            blank_run[i] = 0;
            last_lit[i]  = 4'hF;
        end
    end

    always @(negedge clk) begin
        compare_one(0, b0.an, b0.seg, b0.dp_n);
        compare_one(1, b1.an, b1.seg, b1.dp_n);
    end

    task automatic set_in(logic [3:0] d3, logic [3:0] d2, logic [3:0] d1, logic [3:0] d0,
                          logic [3:0] dp, logic [3:0] bl);
        b0.digit3 = d3; b0.digit2 = d2; b0.digit1 = d1; b0.digit0 = d0;
        b0.dp_in = dp;  b0.blank_in = bl;
        b1.digit3 = d3; b1.digit2 = d2; b1.digit1 = d1; b1.digit0 = d0;
        b1.dp_in = dp;  b1.blank_in = bl;
    endtask

    // Park at the negedge where outputs reflect state cycle c
    task automatic wait_c(int c);
        int g = 0;
        while (cyc != c + 1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c + 1) begin
            checks++;
            errors++;
            $display("FAIL wait_c%0d: got cyc=%0d expected %0d", c, cyc, c + 1);
        end
    endtask

    task automatic check_slot(string nm, int inst, logic [3:0] an_e, logic [6:0] seg_e, logic dp_e);
        logic [3:0] a  = (inst == 0) ? b0.an   : b1.an;
        logic [6:0] s  = (inst == 0) ? b0.seg  : b1.seg;
        logic       d  = (inst == 0) ? b0.dp_n : b1.dp_n;
        checks++;
        if (a !== an_e || s !== seg_e || d !== dp_e) begin
            errors++;
            $display("FAIL %s[%0d]: got an=%b seg=%b dp_n=%b expected an=%b seg=%b dp_n=%b",
                     nm, inst, a, s, d, an_e, seg_e, dp_e);
        end
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) pat[i] = 7'b0111111;

        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        check_slot("reset", 0, 4'b1111, 7'b1111111, 1'b1);
        check_slot("reset", 1, 4'b1111, 7'b1111111, 1'b1);
        rst = 1'b0;

        // Frame 0: shadows still zero
        wait_c(1);
        check_slot("gap_first", 0, 4'b1111, 7'b1111111, 1'b1);
        wait_c(2);
        check_slot("first_lit", 0, 4'b1110, 7'b1000000, 1'b1);
        check_slot("first_lit", 1, 4'b1110, 7'b1000000, 1'b1);
        wait_c(12);
        check_slot("f0_slot1", 0, 4'b1101, 7'b1000000, 1'b1);
        check_slot("f0_slot1_lz", 1, 4'b1101, 7'b1111111, 1'b1);

        // Frame 1: digits 1,2,3,4 visible
        wait_c(33);
        check_slot("f1_gap0", 0, 4'b1111, 7'b1111111, 1'b1);
        wait_c(36);
        check_slot("f1_slot0", 0, 4'b1110, 7'b0011001, 1'b1);
        wait_c(44);
        check_slot("f1_slot1", 0, 4'b1101, 7'b0110000, 1'b1);
        wait_c(52);
        check_slot("f1_slot2", 0, 4'b1011, 7'b0100100, 1'b1);
        wait_c(60);
        check_slot("f1_slot3", 0, 4'b0111, 7'b1111001, 1'b1);

        // digit0 4 -> 9 during slot 0 of frame 2: no tearing until frame 3
        wait_c(66);
        set_in(4'd1, 4'd2, 4'd3, 4'd9, 4'b0000, 4'b0000);
        wait_c(68);
        check_slot("no_tear", 0, 4'b1110, 7'b0011001, 1'b1);
        wait_c(100);
        check_slot("new_digit", 0, 4'b1110, 7'b0010000, 1'b1);

        // Leading-zero suppression with digits 0,0,7,0
        wait_c(110);
        set_in(4'd0, 4'd0, 4'd7, 4'd0, 4'b0000, 4'b0000);
        wait_c(132);
        check_slot("lz_slot0", 1, 4'b1110, 7'b1000000, 1'b1);
        wait_c(140);
        check_slot("lz_slot1", 1, 4'b1101, 7'b1111000, 1'b1);
        wait_c(148);
        check_slot("lz_slot2", 1, 4'b1011, 7'b1111111, 1'b1);
        wait_c(156);
        check_slot("lz_slot3", 1, 4'b0111, 7'b1111111, 1'b1);
        check_slot("nolz_slot3", 0, 4'b0111, 7'b1000000, 1'b1);

        // Dash, decimal point and forced blank
        wait_c(161);
        set_in(4'd0, 4'd12, 4'd7, 4'd0, 4'b0100, 4'b1000);
        wait_c(196);
        check_slot("d0_kept", 1, 4'b1110, 7'b1000000, 1'b1);
        wait_c(212);
        check_slot("dash_dp", 0, 4'b1011, 7'b0111111, 1'b0);
        check_slot("dash_dp", 1, 4'b1011, 7'b0111111, 1'b0);
        wait_c(220);
        check_slot("forced_blank", 0, 4'b0111, 7'b1111111, 1'b1);

        // Asynchronous reset while slot 2 is lit
        wait_c(340);
        check_slot("pre_reset", 0, 4'b1011, 7'b0111111, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_slot("async_reset", 0, 4'b1111, 7'b1111111, 1'b1);
        check_slot("async_reset", 1, 4'b1111, 7'b1111111, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_c(1);
        check_slot("post_gap", 0, 4'b1111, 7'b1111111, 1'b1);
        wait_c(2);
        check_slot("post_first", 0, 4'b1110, 7'b1000000, 1'b1);
        wait_c(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
